// File: rtl/master_out_port.sv
// Master transmit stage: captures one request, waits for slave ready,
// then serializes address and data LSB-first with a launch strobe.
module master_out_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  slave_ready,
    output logic                  master_valid,
    output logic                  tx_address,
    output logic                  tx_data,
    output logic                  read_en,
    output logic                  write_en,
    output logic                  busy,
    output logic                  tx_done,
    output logic                  timeout
);

    localparam int CW = $clog2(ADDR_WIDTH + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_READY,
        SEND
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] addr_sh;
    logic [DATA_WIDTH-1:0] data_sh;
    logic                  mode_q;
    logic [CW-1:0]         bit_cnt;
    logic [WW-1:0]         wait_cnt;
    logic                  wait_expired;
    logic                  last_bit;

    assign wait_expired = (wait_cnt == WW'(TIMEOUT - 1));
    assign last_bit     = (bit_cnt == CW'(ADDR_WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Ready wins over an expiring wait in the same cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = WAIT_READY;
            end
            WAIT_READY: begin
                if (slave_ready)       state_nx = SEND;
                else if (wait_expired) state_nx = IDLE;
            end
            SEND: begin
                if (last_bit) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_sh  <= '0;
            data_sh  <= '0;
            mode_q   <= 1'b0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            tx_done  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    bit_cnt  <= '0;
                    if (start) begin
                        mode_q  <= mode;
                        addr_sh <= addr_in;
                        data_sh <= data_in;
                    end
                end
                WAIT_READY: begin
                    if (slave_ready) begin
                        bit_cnt <= '0;
                    end else if (wait_expired) begin
                        timeout  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                SEND: begin
                    addr_sh <= addr_sh >> 1;
                    data_sh <= data_sh >> 1;
                    if (last_bit) begin
                        tx_done <= 1'b1;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from state so reset clears them without a clock.
    always_comb begin
        master_valid = (state == SEND);
        busy         = (state != IDLE);
        tx_address   = master_valid & addr_sh[0];
        tx_data      = master_valid & mode_q & data_sh[0]
                     & (bit_cnt < CW'(DATA_WIDTH));
        read_en      = master_valid & ~mode_q & (bit_cnt == '0);
        write_en     = master_valid & mode_q & (bit_cnt == '0);
    end

endmodule

// File: tb/tb_master_out_port.sv
// Scoreboard bench for master_out_port: stimulus queues expected
// serial bits, a negedge monitor pops and compares them.
module tb_master_out_port;

    logic        clk;
    logic        reset;
    logic        start;
    logic        start_t;
    logic        mode;
    logic [11:0] addr_in;
    logic [7:0]  data_in;
    logic        slave_ready;
    logic        ready_t;

    logic master_valid, tx_address, tx_data, read_en, write_en;
    logic busy, tx_done, timeout;
    logic mv_t, ta_t, td_t, rd_t, wr_t, busy_t, done_t, to_t;

    typedef struct packed {
        logic a;
        logic d;
        logic rd;
        logic wr;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;

    master_out_port dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .addr_in(addr_in), .data_in(data_in),
        .slave_ready(slave_ready),
        .master_valid(master_valid), .tx_address(tx_address),
        .tx_data(tx_data), .read_en(read_en), .write_en(write_en),
        .busy(busy), .tx_done(tx_done), .timeout(timeout)
    );

    master_out_port #(.TIMEOUT(4)) dut_t (
        .clk(clk), .reset(reset), .start(start_t), .mode(mode),
        .addr_in(addr_in), .data_in(data_in),
        .slave_ready(ready_t),
        .master_valid(mv_t), .tx_address(ta_t),
        .tx_data(td_t), .read_en(rd_t), .write_en(wr_t),
        .busy(busy_t), .tx_done(done_t), .timeout(to_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each presented serial bit against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (master_valid === 1'b1) begin
            chk("exp_queue_nonempty", q.size() > 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("tx_address", tx_address, e.a);
                chk("tx_data", tx_data, e.d);
                chk("read_en", read_en, e.rd);
                chk("write_en", write_en, e.wr);
            end
        end else begin
            chk("idle_lines", {read_en, write_en, tx_address, tx_data}, 0);
        end
        if (tx_done === 1'b1) done_cnt++;
        chk("t_no_frame", {mv_t, rd_t, wr_t, ta_t, td_t}, 0);
    end

    task automatic frame(input logic m, input logic [11:0] a,
                         input logic [7:0] d, input logic [11:0] ea,
                         input logic [11:0] ed, input int delay,
                         input bit inject);
        int dc0;
        dc0 = done_cnt;
        for (int i = 0; i < 12; i++)
            q.push_back(exp_t'{ea[i], ed[i], (i == 0) && !m, (i == 0) && m});
        mode        = m;
        addr_in     = a;
        data_in     = d;
        start       = 1'b1;
        slave_ready = (delay == 0);
        @(posedge clk); #1;
        start   = 1'b0;
        addr_in = '0;
        data_in = '0;
        mode    = ~m;
        chk("busy_capture", busy, 1);
        for (int k = 0; k < delay; k++) begin
            chk("no_valid_wait", master_valid, 0);
            @(posedge clk); #1;
        end
        slave_ready = 1'b1;
        chk("no_valid_before_ready", master_valid, 0);
        @(posedge clk); #1;
        chk("launch_valid", master_valid, 1);
        for (int b = 1; b <= 12; b++) begin
            if (inject && b == 4) begin
                start   = 1'b1;
                addr_in = 12'hFFF;
                mode    = 1'b1;
            end
            if (inject && b == 5) start = 1'b0;
            if (delay > 0 && b == 3) slave_ready = 1'b0;
            @(posedge clk); #1;
            if (b < 12) begin
                chk("valid_hold", master_valid, 1);
                chk("busy_hold", busy, 1);
            end
        end
        start = 1'b0;
        chk("done_pulse", tx_done, 1);
        chk("busy_drop", busy, 0);
        chk("valid_drop", master_valid, 0);
        @(posedge clk); #1;
        chk("done_single", tx_done, 0);
        chk("no_queued_start", busy, 0);
        chk("bits_all_sent", q.size(), 0);
        chk("done_count", done_cnt, dc0 + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int dc0;
        reset       = 1'b1;
        start       = 1'b0;
        start_t     = 1'b0;
        mode        = 1'b0;
        addr_in     = '0;
        data_in     = '0;
        slave_ready = 1'b0;
        ready_t     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            {master_valid, tx_address, tx_data, read_en, write_en,
             busy, tx_done, timeout}, 0);
        chk("reset_outputs_t",
            {mv_t, ta_t, td_t, rd_t, wr_t, busy_t, done_t, to_t}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Write frame: A5C / 3F.
        frame(1'b1, 12'hA5C, 8'h3F, 12'hA5C, 12'h03F, 0, 1'b0);
        // Read frame: data must never appear.
        frame(1'b0, 12'h001, 8'hFF, 12'h001, 12'h000, 0, 1'b0);
        // Ready delayed five cycles, dropped mid-frame.
        frame(1'b1, 12'h3C5, 8'h96, 12'h3C5, 12'h096, 5, 1'b0);
        // Start during SEND is ignored.
        frame(1'b1, 12'h5A3, 8'hC4, 12'h5A3, 12'h0C4, 0, 1'b1);

        // Timeout on the TIMEOUT=4 instance.
        start_t = 1'b1;
        @(posedge clk); #1;
        start_t = 1'b0;
        chk("t_busy_capture", busy_t, 1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            chk("t_timeout_early", to_t, 0);
            chk("t_busy_wait", busy_t, 1);
        end
        @(posedge clk); #1;
        chk("t_timeout_pulse", to_t, 1);
        chk("t_busy_drop", busy_t, 0);
        @(posedge clk); #1;
        chk("t_timeout_single", to_t, 0);

        // Reset in the middle of a write frame at bit 6.
        dc0 = done_cnt;
        for (int i = 0; i < 12; i++)
            q.push_back(exp_t'{1'b1 ^ ((i % 4) == 3), (i < 8) ? (i % 2 == 0) : 1'b0,
                               1'b0, i == 0});
        mode        = 1'b1;
        addr_in     = 12'h777;
        data_in     = 8'h55;
        start       = 1'b1;
        slave_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rst_launch", master_valid, 1);
        repeat (6) @(posedge clk);
        #1;
        chk("bits_before_reset", q.size(), 6);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_async",
            {master_valid, tx_address, tx_data, read_en, write_en,
             busy, tx_done, timeout}, 0);
        q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("no_done_after_reset", done_cnt, dc0);

        // Normal operation after reset.
        frame(1'b0, 12'h8E1, 8'h5A, 12'h8E1, 12'h000, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/master_out_port.md
# master_out_port

Master-side transmit stage that feeds a slave port over the serial system bus. It accepts one parallel request at a time (12-bit address, 8-bit write data, read/write mode) and waits for the slave to signal ready. It then raises `master_valid` and shifts the address and data out LSB-first on two serial lines, with a one-cycle `read_en`/`write_en` strobe that the slave latches. If the slave never becomes ready, the request times out.

## Interface
- `ADDR_WIDTH`, default 12: address bits serialized on `tx_address`.
- `DATA_WIDTH`, default 8: data bits serialized on `tx_data`; must be ≤ `ADDR_WIDTH`.
- `TIMEOUT`, default 64: maximum cycles spent in WAIT_READY before aborting; ≥ 1.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; forces IDLE and reset values immediately.
- `start` in 1: request strobe; sampled only in IDLE.
- `mode` in 1: 1 = write, 0 = read; captured with `start`.
- `addr_in` in `ADDR_WIDTH`: request address; captured with `start`.
- `data_in` in `DATA_WIDTH`: write data; captured with `start`, ignored for reads.
- `slave_ready` in 1: slave can accept a frame.
- `master_valid` out 1: high for exactly the `ADDR_WIDTH` serial bit cycles of a frame.
- `tx_address` out 1: serial address bit.
- `tx_data` out 1: serial data bit.
- `read_en` out 1: one-cycle strobe on the first bit cycle of a read frame.
- `write_en` out 1: one-cycle strobe on the first bit cycle of a write frame.
- `busy` out 1: high from request capture until return to IDLE.
- `tx_done` out 1: one-cycle pulse when a frame completes.
- `timeout` out 1: one-cycle pulse when the wait for ready is aborted.

## Operation
- States: IDLE, WAIT_READY, SEND.
- IDLE:
  - `start`=1 captures `mode`, `addr_in` and `data_in` into shift registers and moves to WAIT_READY.
  - The wait counter clears.
- WAIT_READY:
  - `slave_ready`=1 moves to SEND and loads the bit counter with 0.
  - Otherwise the counter increments. When it reaches `TIMEOUT`-1 with `slave_ready` still 0, the block returns to IDLE and pulses `timeout`.
  - `slave_ready` takes priority over timeout in the same cycle.
- SEND:
  - The block drives `master_valid`=1, `tx_address` = addr shift LSB and `tx_data` = data shift LSB.
  - Both shift registers shift right each cycle.
  - For bit indices ≥ `DATA_WIDTH`, and for all bits of a read, `tx_data`=0.
  - After bit `ADDR_WIDTH`-1 the block returns to IDLE and pulses `tx_done`.
- `slave_ready` is ignored once SEND has been entered; a frame is never paused.
- `start` outside IDLE is ignored, with no queuing. The inputs are not re-sampled mid-frame.
- Bit counter: 4 bits for the default widths (ceil(log2(`ADDR_WIDTH`+1)) in general); no wrap inside a frame.

## Timing
- Reset values: `master_valid`, `tx_address`, `tx_data`, `read_en`, `write_en`, `busy`, `tx_done` and `timeout` are all 0; state is IDLE; counters and shift registers are 0.
- Request capture:
  - Let E0 be the edge that samples `start`=1 in IDLE.
  - `busy`=1 is visible after E0 and drops in the same cycle that `tx_done` or `timeout` is high.
- Frame launch:
  - Let Ek be the edge that samples `slave_ready`=1 in WAIT_READY.
  - After Ek: `master_valid`=1, bit 0 is on both lines, and `read_en` or `write_en` = 1 for that single cycle.
- Bit timing: bit i is driven in the cycle after edge Ek+i, for i = 0..`ADDR_WIDTH`-1.
- Frame completion: after edge Ek+`ADDR_WIDTH`, `master_valid`=0, `tx_done`=1 for one cycle and `busy`=0.
- Minimum request-to-request spacing:
  - With `slave_ready` held high, the next `start` is accepted at edge Ek+`ADDR_WIDTH`+1.
  - Frame length is 1 capture cycle + 1 ready cycle + `ADDR_WIDTH` bit cycles.
- Timeout: with `slave_ready` held 0, `timeout` pulses after edge E0+`TIMEOUT`.
- Reset asserted mid-SEND: all outputs drop to 0 asynchronously. No `tx_done` is issued, and the partial frame is abandoned.

## Test plan
- Write frame: `mode`=1, `addr_in`=12'hA5C, `data_in`=8'h3F, `slave_ready`=1.
  - `write_en` is a single pulse; `master_valid` is high 12 cycles.
  - `tx_address` sequence is 0,0,1,1,1,0,1,0,0,1,0,1.
  - `tx_data` sequence is 1,1,1,1,1,1,0,0 followed by four 0s.
  - `tx_done` pulses once.
- Read frame: `mode`=0, `addr_in`=12'h001, `data_in`=8'hFF.
  - `read_en` pulses and `write_en` stays 0.
  - `tx_data` is 0 for all 12 bits; `tx_address` is 1 then 0s.
- Delayed ready: `slave_ready` low for 5 cycles after capture, then high.
  - `master_valid` rises exactly one cycle after the edge that samples ready, with no bit skipped.
  - Dropping `slave_ready` mid-frame does not alter the stream.
- Timeout: `TIMEOUT`=4, `slave_ready`=0.
  - `timeout` pulses at E0+4 and `busy` falls.
  - `master_valid`, `read_en` and `write_en` never assert.
- Busy and reset behaviour:
  - `start` pulsed during SEND with `addr_in`=12'hFFF is ignored; the current frame completes unchanged.
  - `reset` asserted at bit 6 forces all outputs to 0 before the next clock edge; `tx_done` never pulses.
  - After release, a new `start` works normally.
